// File: rtl/scl_frame_ctrl.sv
// Frame/line sequencer gating the scaler data enable.
// Optional horizontal clipping: define SCL_CTRL_CLIP_EN.
module scl_frame_ctrl #(
  parameter int PIX_W     = 12,
  parameter int LINE_W    = 11,
  parameter int DRAIN_CYC = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic              cfg_mode,
  input  logic              cfg_rsz,
  input  logic [PIX_W-1:0]  cfg_hact,
  input  logic [LINE_W-1:0] cfg_vact,
  input  logic              vs_i,
  input  logic              de_i,
  output logic              scl_i_data_en,
  output logic              scl_cfg_mode,
  output logic              scl_cfg_rsz,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              line_done,
  output logic              frame_done,
  output logic              busy,
  output logic              err_len
);

  localparam int DW =
    (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic              rsz_q, rsz_d;
  logic [PIX_W-1:0]  hact_q, hact_d;
  logic [LINE_W-1:0] vact_q, vact_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              de_q, de_d;
  logic              en_q, en_d;
  logic              ld_q, ld_d;
  logic              fd_q, fd_d;
  logic              err_q, err_d;
  logic              stop_q, stop_d;
  logic              line_keep;
  logic              clip_ok;
  logic              active;

  assign active = (state_q == S_ACTIVE);

  // Vertical decimation follows the shadowed mode, never the live inputs.
  always_comb begin
    line_keep = 1'b1;
    if (mode_q) begin
      if (rsz_q) line_keep = (line_q[1:0] == 2'b00);
      else       line_keep = ~line_q[0];
    end
  end

`ifdef SCL_CTRL_CLIP_EN
  assign clip_ok = (pix_q < hact_q);
`else
  assign clip_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rsz_d   = rsz_q;
    hact_d  = hact_q;
    vact_d  = vact_q;
    pix_d   = pix_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stop_d  = stop_q;
    ld_d    = 1'b0;
    fd_d    = 1'b0;
    de_d    = active & de_i;
    en_d    = de_i & active & line_keep & clip_ok;
    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (ctrl_start && !ctrl_stop) begin
          state_d = S_ARMED;
          err_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (ctrl_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else if (vs_i && cfg_vact != '0) begin
          state_d = S_ACTIVE;
          mode_d  = cfg_mode;
          rsz_d   = cfg_rsz;
          hact_d  = cfg_hact;
          vact_d  = cfg_vact;
          pix_d   = '0;
          line_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (ctrl_stop) stop_d = 1'b1;
        if (vs_i) begin
          err_d  = 1'b1;
          mode_d = cfg_mode;
          rsz_d  = cfg_rsz;
          hact_d = cfg_hact;
          vact_d = cfg_vact;
          pix_d  = '0;
          line_d = '0;
          de_d   = 1'b0;
        end else if (de_i) begin
          if (pix_q != '1) pix_d = pix_q + 1'b1;
        end else if (de_q) begin
          ld_d   = 1'b1;
          pix_d  = '0;
          line_d = line_q + 1'b1;
          if (pix_q != hact_q) err_d = 1'b1;
          if (line_q == vact_q - LINE_W'(1)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (ctrl_stop) stop_d = 1'b1;
        if (cnt_q == DW'(DRAIN_CYC)) begin
          fd_d  = 1'b1;
          cnt_d = '0;
          if (stop_q || ctrl_stop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      rsz_q   <= 1'b0;
      hact_q  <= '0;
      vact_q  <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      de_q    <= 1'b0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rsz_q   <= rsz_d;
      hact_q  <= hact_d;
      vact_q  <= vact_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      de_q    <= de_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  assign scl_i_data_en = en_q;
  assign scl_cfg_mode  = mode_q;
  assign scl_cfg_rsz   = rsz_q;
  assign pix_cnt       = pix_q;
  assign line_cnt      = line_q;
  assign line_done     = ld_q;
  assign frame_done    = fd_q;
  assign busy          = (state_q == S_ACTIVE) |
                         (state_q == S_DRAIN);
  assign err_len       = err_q;

endmodule

// File: tb/tb_scl_frame_ctrl.sv
// Bench for scl_frame_ctrl: queued expected line/frame events
// checked by a monitor on the falling clock edge.
module tb_scl_frame_ctrl;

  localparam int PW = 12;
  localparam int LW = 11;
`ifdef SCL_CTRL_CLIP_EN
  localparam int LONG_EN = 8;
`else
  localparam int LONG_EN = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctrl_start = 1'b0;
  logic          ctrl_stop = 1'b0;
  logic          cfg_mode = 1'b0;
  logic          cfg_rsz = 1'b0;
  logic [PW-1:0] cfg_hact = '0;
  logic [LW-1:0] cfg_vact = '0;
  logic          vs_i = 1'b0;
  logic          de_i = 1'b0;
  logic          scl_i_data_en;
  logic          scl_cfg_mode;
  logic          scl_cfg_rsz;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic          line_done;
  logic          frame_done;
  logic          busy;
  logic          err_len;

  scl_frame_ctrl #(
    .PIX_W(PW), .LINE_W(LW), .DRAIN_CYC(7)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .cfg_mode(cfg_mode), .cfg_rsz(cfg_rsz),
    .cfg_hact(cfg_hact), .cfg_vact(cfg_vact),
    .vs_i(vs_i), .de_i(de_i),
    .scl_i_data_en(scl_i_data_en),
    .scl_cfg_mode(scl_cfg_mode),
    .scl_cfg_rsz(scl_cfg_rsz),
    .pix_cnt(pix_cnt), .line_cnt(line_cnt),
    .line_done(line_done), .frame_done(frame_done),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit fr;
    int en;
    bit err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc = 0;
  int   since = 0;
  int   en_total = 0;

  task automatic check(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_line(int en, bit err);
    exp_t e;
    e.fr = 1'b0; e.en = en; e.err = err;
    q.push_back(e);
  endtask

  task automatic exp_frame(bit err);
    exp_t e;
    e.fr = 1'b1; e.en = 0; e.err = err;
    q.push_back(e);
  endtask

  // Monitor: enables per line, line_done/frame_done against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      acc   = 0;
      since = 0;
    end else begin
      since++;
      if (scl_i_data_en) begin
        acc++;
        en_total++;
      end
      if (line_done) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious line_done: got pulse, expected none");
        end else begin
          e = q.pop_front();
          check("event kind at line_done", e.fr, 0);
          check("enables per line", acc, e.en);
          check("err_len at line_done", err_len, e.err);
        end
        acc   = 0;
        since = 0;
      end
      if (frame_done) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious frame_done: got pulse, expected none");
        end else begin
          e = q.pop_front();
          check("event kind at frame_done", e.fr, 1);
          check("frame_done delay", since, 8);
          check("err_len at frame_done", err_len, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(int n);
    de_i = 1'b1;
    repeat (n) tick();
    de_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic pulse_vs();
    vs_i = 1'b1; tick(); vs_i = 1'b0;
  endtask

  task automatic pulse_start();
    ctrl_start = 1'b1; tick(); ctrl_start = 1'b0;
  endtask

  task automatic pulse_stop();
    ctrl_stop = 1'b1; tick(); ctrl_stop = 1'b0;
  endtask

  task automatic set_cfg(bit m, bit r, int h, int v);
    cfg_mode = m;
    cfg_rsz  = r;
    cfg_hact = PW'(h);
    cfg_vact = LW'(v);
  endtask

  int snap;

  initial begin
    @(negedge clk);
    check("reset outputs", {scl_i_data_en, scl_cfg_mode,
      scl_cfg_rsz, pix_cnt, line_cnt, line_done,
      frame_done, busy, err_len}, 0);
    tick();
    rst = 1'b1;
    tick();

    // Bypass frame (rsz=1 has no effect in bypass)
    pulse_start();
    check("busy while armed", busy, 0);
    set_cfg(1'b0, 1'b1, 8, 4);
    pulse_vs();
    check("busy after vs", busy, 1);
    for (int i = 0; i < 4; i++) exp_line(8, 1'b0);
    exp_frame(1'b0);
    for (int i = 0; i < 4; i++) send_line(8);
    repeat (12) tick();
    check("busy after frame", busy, 0);

    // Vertical 1/2
    set_cfg(1'b1, 1'b0, 8, 6);
    vs_i = 1'b1;
    @(negedge clk);
    check("mode before vs edge", scl_cfg_mode, 0);
    check("rsz before vs edge", scl_cfg_rsz, 1);
    tick();
    vs_i = 1'b0;
    check("mode after vs", scl_cfg_mode, 1);
    check("rsz after vs", scl_cfg_rsz, 0);
    for (int i = 0; i < 6; i++) exp_line((i % 2 == 0) ? 8 : 0, 1'b0);
    exp_frame(1'b0);
    for (int i = 0; i < 6; i++) send_line(8);
    repeat (12) tick();

    // Vertical 1/4 with mid-frame rsz change
    set_cfg(1'b1, 1'b1, 8, 8);
    pulse_vs();
    for (int i = 0; i < 8; i++) exp_line((i % 4 == 0) ? 8 : 0, 1'b0);
    exp_frame(1'b0);
    send_line(8);
    send_line(8);
    cfg_rsz = 1'b0;
    for (int i = 2; i < 8; i++) send_line(8);
    check("rsz shadow held", scl_cfg_rsz, 1);
    repeat (12) tick();

    // Length error and clip
    set_cfg(1'b0, 1'b0, 8, 2);
    pulse_vs();
    exp_line(LONG_EN, 1'b1);
    exp_line(8, 1'b1);
    exp_frame(1'b1);
    send_line(10);
    send_line(8);
    repeat (12) tick();

    // Clear error: back to IDLE, then re-arm
    pulse_stop();
    check("err sticky in idle", err_len, 1);
    pulse_start();
    check("err cleared by start", err_len, 0);

    // Stop during line 1
    set_cfg(1'b0, 1'b0, 8, 4);
    pulse_vs();
    for (int i = 0; i < 4; i++) exp_line(8, 1'b0);
    exp_frame(1'b0);
    send_line(8);
    pulse_stop();
    for (int i = 1; i < 4; i++) send_line(8);
    repeat (12) tick();
    check("busy after stopped frame", busy, 0);
    snap = en_total;
    pulse_vs();
    send_line(8);
    repeat (4) tick();
    check("no enables in idle", en_total - snap, 0);
    ctrl_start = 1'b1; ctrl_stop = 1'b1;
    tick();
    ctrl_start = 1'b0; ctrl_stop = 1'b0;
    pulse_vs();
    send_line(8);
    repeat (4) tick();
    check("stop wins over start", en_total - snap, 0);
    check("busy after start+stop", busy, 0);

    // Early vs on line 2
    pulse_start();
    set_cfg(1'b0, 1'b0, 8, 4);
    pulse_vs();
    exp_line(8, 1'b0);
    exp_line(8, 1'b0);
    send_line(8);
    send_line(8);
    check("line_cnt before early vs", line_cnt, 2);
    pulse_vs();
    check("err after early vs", err_len, 1);
    check("line_cnt after early vs", line_cnt, 0);
    check("busy after early vs", busy, 1);
    for (int i = 0; i < 4; i++) exp_line(8, 1'b1);
    exp_frame(1'b1);
    for (int i = 0; i < 4; i++) send_line(8);
    repeat (12) tick();

    // Async reset on line 2
    set_cfg(1'b1, 1'b1, 8, 4);
    pulse_vs();
    exp_line(8, 1'b1);
    exp_line(0, 1'b1);
    send_line(8);
    send_line(8);
    de_i = 1'b1;
    repeat (4) tick();
    check("busy mid line 2", busy, 1);
    #3 rst = 1'b0;
    #1;
    check("outputs on async reset", {scl_i_data_en,
      scl_cfg_mode, scl_cfg_rsz, pix_cnt, line_cnt,
      line_done, frame_done, busy, err_len}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    de_i = 1'b0;
    tick();
    snap = en_total;
    pulse_vs();
    send_line(8);
    repeat (15) tick();
    check("no enables after reset", en_total - snap, 0);
    check("busy after reset", busy, 0);
    pulse_start();
    set_cfg(1'b0, 1'b0, 8, 1);
    pulse_vs();
    exp_line(8, 1'b0);
    exp_frame(1'b0);
    send_line(8);
    repeat (12) tick();

    check("events left in queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
